onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter.sv | 63 ++++++
 tb/tb_onchip_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-requester round-robin arbiter in front of a single-port on-chip memory with 1-clk read return
module onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic last_grant, rd_valid, rd_owner;
  logic req0, req1, grant0, grant1, rd_start;
  // last_grant = 1 means m1 won last, so m0 takes the next contest
  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign grant0   = req0 & (~req1 | last_grant);
  assign grant1   = req1 & ~grant0;
  assign rd_start = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
  assign m0_waitrequest   = req0 & ~grant0;
  assign m1_waitrequest   = req1 & ~grant1;
  assign mem_address      = grant0 ? m0_address : grant1 ? m1_address : '0;
  assign mem_byteenable   = grant0 ? m0_byteenable : grant1 ? m1_byteenable : '0;
  assign mem_writedata    = grant0 ? m0_writedata : grant1 ? m1_writedata : '0;
  assign mem_chipselect   = grant0 | grant1;
  assign mem_write        = (grant0 & m0_write) | (grant1 & m1_write);
  assign mem_clken        = 1'b1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_valid & ~rd_owner;
  assign m1_readdatavalid = rd_valid & rd_owner;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_valid   <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (grant0 | grant1) last_grant <= grant1;
      rd_valid <= rd_start;
      if (rd_start) rd_owner <= grant1;
    end
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed and randomized checks of onchip_mem_arbiter against a transaction-level model
module tb_onchip_mem_arbiter;
  logic clk = 0, reset = 1;
  logic [9:0] m0_address, m1_address, mem_address;
  logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_env [0:1023];
  logic [31:0] ref_mem [0:1023];
  int chk = 0, err = 0;
  bit m_last;
  bit exp_rdv0, exp_rdv1;
  logic [31:0] exp_data;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // memory environment: single-port RAM with byte enables and 1-clk read latency
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) if (mem_byteenable[b]) mem_env[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else mem_readdata <= mem_env[mem_address];
    end
  end

  function automatic int win(bit q0, bit q1);
    if (q0 && q1) return m_last ? 0 : 1;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  task set_m0(input bit r, input bit w, input [9:0] a, input [3:0] be, input [31:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task set_m1(input bit r, input bit w, input [9:0] a, input [3:0] be, input [31:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task idle();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
  endtask

  // clock the model alongside the DUT: one transfer per edge, winner per arbitration rules
  task advance();
    int w;
    bit wr, rd;
    logic [9:0] a;
    logic [3:0] be;
    logic [31:0] d;
    @(posedge clk);
    w = win(m0_read | m0_write, m1_read | m1_write);
    wr = (w == 0) ? m0_write : (w == 1) ? m1_write : 0;
    rd = (w == 0) ? m0_read : (w == 1) ? m1_read : 0;
    a = (w == 0) ? m0_address : m1_address;
    be = (w == 0) ? m0_byteenable : m1_byteenable;
    d = (w == 0) ? m0_writedata : m1_writedata;
    exp_rdv0 = 0; exp_rdv1 = 0;
    if (w >= 0) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else exp_data = ref_mem[a];
    end
    if (reset) m_last = 1;
    else begin
      if (w >= 0) m_last = (w == 1);
      if (rd && !wr) begin
        exp_rdv0 = (w == 0);
        exp_rdv1 = (w == 1);
      end
    end
    @(negedge clk);
  endtask

  task test_reset();
    @(negedge clk);
    set_m0(1, 0, 10'h007, 4'hf, 0);
    set_m1(1, 0, 10'h009, 4'hf, 0);
    #1;
    chk++; if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin err++; $display("FAIL reset_rdv got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    chk++; if (m0_waitrequest !== 0 || m1_waitrequest !== 1) begin err++; $display("FAIL reset_grant wait got %b%b want 01", m0_waitrequest, m1_waitrequest); end
    chk++; if (mem_address !== 10'h007 || mem_clken !== 1) begin err++; $display("FAIL reset_mem addr got %h clken %b want 007 1", mem_address, mem_clken); end
    advance();
    reset = 0;
    idle();
    #1;
    chk++; if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin err++; $display("FAIL post_reset_rdv got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    chk++; if (mem_chipselect !== 0 || mem_write !== 0 || mem_address !== 0 || mem_byteenable !== 0 || mem_writedata !== 0) begin
      err++; $display("FAIL idle_mem cs %b wr %b addr %h be %h wd %h want all 0", mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata); end
    advance();
  endtask

  task test_single_read();
    set_m0(1, 0, 10'h005, 4'hf, 0);
    #1;
    chk++; if (m0_waitrequest !== 0 || mem_address !== 10'h005 || mem_chipselect !== 1 || mem_write !== 0) begin
      err++; $display("FAIL single_read wait %b addr %h cs %b wr %b want 0 005 1 0", m0_waitrequest, mem_address, mem_chipselect, mem_write); end
    advance();
    idle();
    #1;
    chk++; if (m0_readdatavalid !== 1 || m1_readdatavalid !== 0 || m0_readdata !== ref_mem[5]) begin
      err++; $display("FAIL single_read_ret rdv %b%b data %h want 10 %h", m0_readdatavalid, m1_readdatavalid, m0_readdata, ref_mem[5]); end
    advance();
  endtask

  task pulse_reset();
    reset = 1;
    advance();
    reset = 0;
  endtask

  task test_contention();
    pulse_reset();
    set_m0(1, 0, 10'h021, 4'hf, 0);
    set_m1(1, 0, 10'h042, 4'hf, 0);
    #1;
    chk++; if (m0_waitrequest !== 0 || m1_waitrequest !== 1 || mem_address !== 10'h021) begin
      err++; $display("FAIL contend_c1 wait %b%b addr %h want 01 021", m0_waitrequest, m1_waitrequest, mem_address); end
    advance();
    set_m0(0, 0, 0, 0, 0);
    #1;
    chk++; if (m1_waitrequest !== 0 || mem_address !== 10'h042) begin err++; $display("FAIL contend_c2 wait1 %b addr %h want 0 042", m1_waitrequest, mem_address); end
    chk++; if (m0_readdatavalid !== 1 || m1_readdatavalid !== 0 || m0_readdata !== ref_mem[10'h021]) begin
      err++; $display("FAIL contend_ret0 rdv %b%b data %h want 10 %h", m0_readdatavalid, m1_readdatavalid, m0_readdata, ref_mem[10'h021]); end
    advance();
    idle();
    #1;
    chk++; if (m1_readdatavalid !== 1 || m0_readdatavalid !== 0 || m1_readdata !== ref_mem[10'h042]) begin
      err++; $display("FAIL contend_ret1 rdv %b%b data %h want 01 %h", m0_readdatavalid, m1_readdatavalid, m1_readdata, ref_mem[10'h042]); end
    advance();
  endtask

  task test_alternation();
    int n0 = 0, n1 = 0, cyc = 0, prev = -1, w, bad = 0;
    while ((n0 < 8 || n1 < 8) && cyc < 40) begin
      set_m0(n0 < 8, 0, 10'(n0 + 10'h100), 4'hf, 0);
      set_m1(n1 < 8, 0, 10'(n1 + 10'h200), 4'hf, 0);
      #1;
      w = win(m0_read, m1_read);
      if (w == prev || (m0_read && m0_waitrequest !== (w != 0)) || (m1_read && m1_waitrequest !== (w != 1))) bad++;
      if (cyc > 0 && (m0_readdatavalid !== exp_rdv0 || m1_readdatavalid !== exp_rdv1 || (exp_rdv0 | exp_rdv1) && m0_readdata !== exp_data)) bad++;
      prev = w;
      advance();
      if (w == 0) n0++;
      if (w == 1) n1++;
      cyc++;
    end
    idle();
    #1;
    chk++; if (cyc !== 16 || bad !== 0) begin err++; $display("FAIL alternation cycles %0d bad %0d want 16 0", cyc, bad); end
    chk++; if (m0_readdatavalid !== exp_rdv0 || m1_readdatavalid !== exp_rdv1 || exp_rdv0 == exp_rdv1) begin
      err++; $display("FAIL alternation_tail rdv %b%b want %b%b", m0_readdatavalid, m1_readdatavalid, exp_rdv0, exp_rdv1); end
    advance();
  endtask

  task test_write_byteenable();
    logic [31:0] old, want;
    old = ref_mem[10'h3ff];
    want = {old[31:16], 16'hBEEF};
    set_m1(0, 1, 10'h3ff, 4'h3, 32'hDEADBEEF);
    #1;
    chk++; if (mem_write !== 1 || mem_byteenable !== 4'h3 || mem_writedata !== 32'hDEADBEEF || mem_address !== 10'h3ff) begin
      err++; $display("FAIL be_write wr %b be %h wd %h addr %h want 1 3 deadbeef 3ff", mem_write, mem_byteenable, mem_writedata, mem_address); end
    advance();
    idle();
    set_m0(1, 0, 10'h3ff, 4'hf, 0);
    #1;
    chk++; if (m1_readdatavalid !== 0 || m0_readdatavalid !== 0) begin err++; $display("FAIL be_write_rdv rdv %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    advance();
    idle();
    #1;
    chk++; if (m0_readdatavalid !== 1 || m0_readdata !== want) begin err++; $display("FAIL be_readback rdv %b data %h want 1 %h", m0_readdatavalid, m0_readdata, want); end
    advance();
  endtask

  task test_reset_mid_read();
    set_m0(1, 0, 10'h010, 4'hf, 0);
    #1;
    chk++; if (m0_waitrequest !== 0 || mem_chipselect !== 1) begin err++; $display("FAIL rst_mid_grant wait %b cs %b want 0 1", m0_waitrequest, mem_chipselect); end
    #2 reset = 1;
    advance();
    idle();
    #1;
    chk++; if (m0_readdatavalid !== 0 || m1_readdatavalid !== 0) begin err++; $display("FAIL rst_mid_rdv rdv %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    advance();
    reset = 0;
    set_m0(1, 0, 10'h011, 4'hf, 0);
    set_m1(1, 0, 10'h012, 4'hf, 0);
    #1;
    chk++; if (m0_waitrequest !== 0 || m1_waitrequest !== 1) begin err++; $display("FAIL rst_mid_contest wait %b%b want 01", m0_waitrequest, m1_waitrequest); end
    advance();
    set_m0(0, 0, 0, 0, 0);
    advance();
    idle();
    advance();
  endtask

  task test_read_write_both();
    set_m0(1, 1, 10'h030, 4'hf, 32'h12345678);
    #1;
    chk++; if (mem_write !== 1 || mem_writedata !== 32'h12345678 || m0_waitrequest !== 0) begin
      err++; $display("FAIL rw_both wr %b wd %h wait %b want 1 12345678 0", mem_write, mem_writedata, m0_waitrequest); end
    advance();
    set_m0(1, 0, 10'h030, 4'hf, 0);
    #1;
    chk++; if (m0_readdatavalid !== 0) begin err++; $display("FAIL rw_both_rdv got %b want 0", m0_readdatavalid); end
    advance();
    idle();
    #1;
    chk++; if (m0_readdatavalid !== 1 || m0_readdata !== 32'h12345678) begin err++; $display("FAIL rw_both_readback rdv %b data %h want 1 12345678", m0_readdatavalid, m0_readdata); end
    advance();
  endtask

  task test_random();
    bit p0 = 0, p1 = 0;
    bit r0, w0, r1, w1;
    logic [9:0] a0, a1;
    logic [3:0] b0, b1;
    logic [31:0] d0, d1;
    int w, k, bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 3); p0 = 1; r0 = (k != 2); w0 = (k >= 2);
        a0 = 10'($urandom_range(0, 15)); b0 = 4'($urandom); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 3); p1 = 1; r1 = (k != 2); w1 = (k >= 2);
        a1 = 10'($urandom_range(0, 15)); b1 = 4'($urandom); d1 = $urandom;
      end
      if (p0) set_m0(r0, w0, a0, b0, d0); else set_m0(0, 0, 0, 0, 0);
      if (p1) set_m1(r1, w1, a1, b1, d1); else set_m1(0, 0, 0, 0, 0);
      #1;
      w = win(p0, p1);
      chk++; if (m0_waitrequest !== (p0 && w != 0) || m1_waitrequest !== (p1 && w != 1)) begin
        err++; bad++; if (bad < 10) $display("FAIL rand_wait cyc %0d got %b%b want %b%b", i, m0_waitrequest, m1_waitrequest, p0 && w != 0, p1 && w != 1); end
      chk++; if (mem_chipselect !== (w >= 0) || mem_write !== (w == 0 ? w0 : w == 1 ? w1 : 1'b0)
                 || mem_address !== (w == 0 ? a0 : w == 1 ? a1 : 10'h0)) begin
        err++; bad++; if (bad < 10) $display("FAIL rand_mem cyc %0d cs %b wr %b addr %h winner %0d", i, mem_chipselect, mem_write, mem_address, w); end
      chk++; if (m0_readdatavalid !== exp_rdv0 || m1_readdatavalid !== exp_rdv1 || (exp_rdv0 && m0_readdata !== exp_data) || (exp_rdv1 && m1_readdata !== exp_data)) begin
        err++; bad++; if (bad < 10) $display("FAIL rand_ret cyc %0d rdv %b%b data %h want %b%b %h", i, m0_readdatavalid, m1_readdatavalid, m0_readdata, exp_rdv0, exp_rdv1, exp_data); end
      advance();
      if (w == 0) p0 = 0;
      if (w == 1) p1 = 0;
    end
    idle();
    advance();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      mem_env[i] = ref_mem[i];
    end
    mem_readdata = 0;
    m_last = 1; exp_rdv0 = 0; exp_rdv1 = 0; exp_data = 0;
    idle();
    test_reset();
    test_single_read();
    test_contention();
    test_alternation();
    test_write_byteenable();
    test_reset_mid_read();
    test_read_write_both();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
